// File: rtl/conv_result_unloader.sv
// conv_result_unloader
//
// Takes a complete complex result frame from the convolver in one cycle and
// plays it out as a valid/ready sample stream, one sample per beat.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for conv_done; a clean strobe captures the frame
// STREAM | presenting samples 0..NUM_OUT-1 under valid/ready handshake
// DONE   | last sample accepted; frame_done pulses, then back to IDLE
//
// Parameters:
//   QI, QF       integer / fractional bits per fixed-point component
//   NUM_ELEMS    convolver input length; NUM_OUT = NUM_ELEMS+4 samples/frame
//   WORD_LENGTH  component width W (default QI+QF)
//
// Ports:
//   clk            single clock, posedge
//   rst            synchronous active-low reset
//   res_in         flattened frame: sample k Re at [2kW +: W], Im at [(2k+1)W +: W]
//   conv_done      frame-complete strobe, res_in valid in the same cycle
//   conv_overflow  convolver overflow, qualified by conv_done
//   m_ready        downstream ready
//   m_valid        output sample valid
//   m_re, m_im     signed sample components, bit-exact from the frame
//   m_idx          index of the presented sample within the frame
//   m_last         high with the final sample of the frame
//   busy           high whenever not IDLE
//   frame_done     one-cycle pulse after the last transfer
//   err_overflow   sticky: a frame was rejected because of convolver overflow
//   err_dropped    sticky: conv_done arrived while a frame was in flight
//
// Build option:
//   CONV_UNLOAD_REVERSE_EN  when defined, beat k carries buffer sample
//                           NUM_OUT-1-k (m_idx still counts 0..NUM_OUT-1).

module conv_result_unloader #(
    parameter int QI          = 3,
    parameter int QF          = 3,
    parameter int NUM_ELEMS   = 100,
    parameter int WORD_LENGTH = QI + QF
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [2*WORD_LENGTH*(NUM_ELEMS+4)-1:0]      res_in,
    input  logic                                        conv_done,
    input  logic                                        conv_overflow,
    input  logic                                        m_ready,
    output logic                                        m_valid,
    output logic signed [WORD_LENGTH-1:0]               m_re,
    output logic signed [WORD_LENGTH-1:0]               m_im,
    output logic [$clog2(NUM_ELEMS+4)-1:0]              m_idx,
    output logic                                        m_last,
    output logic                                        busy,
    output logic                                        frame_done,
    output logic                                        err_overflow,
    output logic                                        err_dropped
);

    localparam int W       = WORD_LENGTH;
    localparam int NUM_OUT = NUM_ELEMS + 4;
    localparam int IDX_W   = $clog2(NUM_OUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

`ifdef CONV_UNLOAD_REVERSE_EN
    localparam int FIRST_SAMPLE = NUM_OUT - 1;
`else
    localparam int FIRST_SAMPLE = 0;
`endif

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]              state;
    logic signed [W-1:0]     re_buf [NUM_OUT];
    logic signed [W-1:0]     im_buf [NUM_OUT];
    logic                    capture;
    logic [IDX_W-1:0]        idx_nxt;
    logic [IDX_W-1:0]        sel_nxt;

    assign capture = (state == IDLE) && conv_done && !conv_overflow;

    always_comb begin
        idx_nxt = m_idx + IDX_W'(1);
`ifdef CONV_UNLOAD_REVERSE_EN
        sel_nxt = LAST_IDX - idx_nxt;
`else
        sel_nxt = idx_nxt;
`endif
    end

    // Frame storage carries no reset: it is only read after a capture has
    // refilled it, and the FSM reset alone abandons an in-flight frame.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                re_buf[k] <= res_in[2*k*W +: W];
                im_buf[k] <= res_in[(2*k+1)*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            m_valid      <= 1'b0;
            m_re         <= '0;
            m_im         <= '0;
            m_idx        <= '0;
            m_last       <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            err_overflow <= 1'b0;
            err_dropped  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (conv_done) begin
                        if (conv_overflow) begin
                            err_overflow <= 1'b1;
                        end else begin
                            // Sample 0 is taken straight from res_in so that
                            // m_valid rises one cycle after conv_done.
                            state        <= STREAM;
                            busy         <= 1'b1;
                            m_valid      <= 1'b1;
                            m_idx        <= '0;
                            m_last       <= (NUM_OUT == 1);
                            m_re         <= res_in[2*FIRST_SAMPLE*W +: W];
                            m_im         <= res_in[(2*FIRST_SAMPLE+1)*W +: W];
                            err_overflow <= 1'b0;
                            err_dropped  <= 1'b0;
                        end
                    end
                end
                STREAM: begin
                    if (conv_done) begin
                        err_dropped <= 1'b1;
                    end
                    if (m_valid && m_ready) begin
                        if (m_idx == LAST_IDX) begin
                            state      <= DONE;
                            m_valid    <= 1'b0;
                            m_last     <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            m_idx  <= idx_nxt;
                            m_re   <= re_buf[sel_nxt];
                            m_im   <= im_buf[sel_nxt];
                            m_last <= (idx_nxt == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    if (conv_done) begin
                        err_dropped <= 1'b1;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/conv_result_unloader.md
CONV_RESULT_UNLOADER -- requirements
Module: conv_result_unloader

Interface
REQ-001 Parameter QI, default 3: integer bits per fixed-point component.
REQ-002 Parameter QF, default 3: fractional bits per fixed-point component.
REQ-003 Parameter NUM_ELEMS, default 100: input signal length of the producing convolver; NUM_OUT = NUM_ELEMS+4 result samples per frame.
REQ-004 Parameter WORD_LENGTH, default QI+QF: component width W.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 rst  in  1  synchronous active-low reset.
REQ-007 res_in  in  2*W*NUM_OUT  flattened complex frame; sample k Re at [(2k+1)W-1:2kW], Im at [(2k+2)W-1:(2k+1)W].
REQ-008 conv_done  in  1  frame-complete strobe from convolver; res_in valid in the same cycle.
REQ-009 conv_overflow  in  1  convolver overflow flag, qualified by conv_done.
REQ-010 m_ready  in  1  downstream ready.
REQ-011 m_valid  out  1  output sample valid.
REQ-012 m_re, m_im  out  W each  signed output sample components.
REQ-013 m_idx  out  clog2(NUM_OUT)  index of the current sample in the frame.
REQ-014 m_last  out  1  high with the final sample of a frame.
REQ-015 busy  out  1  high when not IDLE.
REQ-016 frame_done  out  1  one-cycle pulse after the last transfer.
REQ-017 err_overflow, err_dropped  out  1 each  sticky error flags.

Function
REQ-018 The block SHALL use states IDLE, STREAM, DONE; all outputs registered.
REQ-019 In IDLE, conv_done=1 with conv_overflow=0 SHALL capture res_in into an internal frame buffer, set index=0, go to STREAM; m_valid SHALL rise the next cycle with sample 0 (latency 1 cycle).
REQ-020 In IDLE, conv_done=1 with conv_overflow=1 SHALL set err_overflow, capture nothing, stay in IDLE.
REQ-021 A transfer SHALL occur when m_valid=1 and m_ready=1 in the same cycle.
REQ-022 While m_valid=1 and m_ready=0, m_re, m_im, m_idx, m_last SHALL hold stable; m_valid SHALL not drop.
REQ-023 On a transfer at index < NUM_OUT-1 the next sample SHALL be presented the following cycle (one sample per cycle at full throughput).
REQ-024 m_last SHALL be 1 exactly when m_idx = NUM_OUT-1 and m_valid=1.
REQ-025 On transfer of the last sample, the block SHALL go to DONE, deassert m_valid, pulse frame_done for one cycle, then return to IDLE.
REQ-026 conv_done asserted in STREAM or DONE SHALL be ignored for data and SHALL set err_dropped; the buffer SHALL not change.
REQ-027 Error flags SHALL clear only on reset or on the next accepted (non-overflow) capture in IDLE.
REQ-028 Components SHALL pass through bit-exact, no rescaling or sign change.

Reset
REQ-029 With rst=0 at a clock edge: state IDLE, index 0, m_valid 0, m_re/m_im/m_idx 0, m_last 0, busy 0, frame_done 0, err_overflow 0, err_dropped 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no further m_valid until a new conv_done.

Configuration
REQ-031 Macro CONV_UNLOAD_REVERSE_EN: when defined, sample k on the output SHALL be buffer sample NUM_OUT-1-k (m_idx still counts 0..NUM_OUT-1); when undefined, output order is buffer order 0..NUM_OUT-1.

Verification (NUM_ELEMS=4, NUM_OUT=8, W=6)
REQ-032 Frame with sample k = (Re=k, Im=-k), m_ready=1 -> 8 consecutive beats starting 1 cycle after conv_done, m_idx 0..7, m_last on beat 7, frame_done 1 cycle after beat 7.
REQ-033 Same frame, m_ready toggling 1,0,0,1 -> outputs held during stalls, all 8 samples in order, none duplicated.
REQ-034 conv_done with conv_overflow=1 -> err_overflow=1, m_valid stays 0, busy stays 0.
REQ-035 Second conv_done at beat 3 -> err_dropped=1, remaining beats carry the first frame's data.
REQ-036 rst=0 at beat 4 -> all outputs zero next cycle, no further beats until a new conv_done.
REQ-037 With CONV_UNLOAD_REVERSE_EN defined, same frame -> beats carry Re=7..0, Im=-7..0, m_idx 0..7.
